// File: rtl/tester_pkg.sv
// Shared types and segment constants for the error-count display path.
// Segment constants are active-low, bit order gfedcba.
package tester_pkg;

  typedef enum logic [1:0] {RUN, FROZEN, SAT} state_t;

  localparam logic [2:0] MODE_COUNT = 3'd0;
  localparam logic [2:0] MODE_FIRST = 3'd1;
  localparam logic [2:0] MODE_LIVE  = 3'd2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  localparam logic [15:0] COUNT_MAX = 16'h9999;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Four-digit BCD increment, each digit wraps 9->0 and carries up.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/error_count_display_if.sv
// Controller/operator inputs and display/status outputs of error_count_display.
interface error_count_display_if #(parameter int K_W = 6);
  logic           error_flag;
  logic [K_W-1:0] K;
  logic           stop;
  logic           continua;
  logic           count_clear;
  logic [2:0]     switchesH;
  logic [6:0]     dispUnidade;
  logic [6:0]     dispDezena;
  logic [6:0]     dispCentena;
  logic [6:0]     dispMilhar;
  logic [K_W-1:0] first_fail_k;
  logic           first_fail_valid;
  logic           err_saturated;

  modport master (
    output error_flag, K, stop, continua, count_clear, switchesH,
    input  dispUnidade, dispDezena, dispCentena, dispMilhar,
           first_fail_k, first_fail_valid, err_saturated
  );

  modport slave (
    input  error_flag, K, stop, continua, count_clear, switchesH,
    output dispUnidade, dispDezena, dispCentena, dispMilhar,
           first_fail_k, first_fail_valid, err_saturated
  );
endinterface

// File: rtl/bcd_to_7seg.sv
// One BCD digit plus blank flag to 7 segments (gfedcba); non-decimal codes show blank.
module bcd_to_7seg
  import tester_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] seg_low;

  always_comb begin
    seg_low = blank ? SEG_BLANK : digit_seg(bcd);
    seg     = SEG_ACTIVE_LOW ? seg_low : ~seg_low;
  end

endmodule

// File: rtl/error_count_display.sv
// BCD error counter with first-fail latch, freeze/resume control and registered 7-segment drive.
// Build option: LEAD_ZERO_BLANK_EN blanks leading zero digits in count mode.
//
// state  | meaning
// RUN    | counting rising edges of error_flag
// FROZEN | count held for reading, waits for continua rise with stop low
// SAT    | count pinned at 9999 until count_clear or reset
module error_count_display
  import tester_pkg::*;
#(
  parameter int K_W            = 6,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic                 sys_clock,
  input logic                 sys_reset,
  error_count_display_if.slave bus
);

  localparam logic [6:0] SEG_ZERO_OUT = SEG_ACTIVE_LOW ? SEG_0 : ~SEG_0;
  localparam logic [6:0] SEG_OFF_OUT  = SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;
`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [6:0] SEG_RST_UPPER = SEG_OFF_OUT;
`else
  localparam logic [6:0] SEG_RST_UPPER = SEG_ZERO_OUT;
`endif

  state_t         state, state_nxt;
  logic [15:0]    count, count_nxt;
  logic [K_W-1:0] ffk, ffk_nxt;
  logic           ffv, ffv_nxt;
  logic           sat, sat_nxt;
  logic           err_prev, cont_prev;
  logic           err_pulse, cont_rise;

  assign err_pulse = bus.error_flag & ~err_prev;
  assign cont_rise = bus.continua & ~cont_prev;

  always_ff @(posedge sys_clock or negedge sys_reset) begin
    if (!sys_reset) begin
      state     <= RUN;
      count     <= 16'h0000;
      ffk       <= '0;
      ffv       <= 1'b0;
      sat       <= 1'b0;
      err_prev  <= 1'b0;
      cont_prev <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      ffk       <= ffk_nxt;
      ffv       <= ffv_nxt;
      sat       <= sat_nxt;
      err_prev  <= bus.error_flag;
      cont_prev <= bus.continua;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    ffk_nxt   = ffk;
    ffv_nxt   = ffv;
    sat_nxt   = sat;
    if (bus.count_clear) begin
      state_nxt = RUN;
      count_nxt = 16'h0000;
      ffk_nxt   = '0;
      ffv_nxt   = 1'b0;
      sat_nxt   = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.stop) begin
            state_nxt = FROZEN;
          end else if (err_pulse) begin
            count_nxt = bcd_inc(count);
            if (count == 16'h0000) begin
              ffk_nxt = bus.K;
              ffv_nxt = 1'b1;
            end
            if (count_nxt == COUNT_MAX) begin
              state_nxt = SAT;
              sat_nxt   = 1'b1;
            end
          end
        end
        FROZEN: begin
          if (cont_rise && !bus.stop) state_nxt = RUN;
        end
        SAT: begin
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign bus.first_fail_k     = ffk;
  assign bus.first_fail_valid = ffv;
  assign bus.err_saturated    = sat;

  // Digit selection per display mode; index 0 is units.
  logic [K_W-1:0] dec_val;
  logic [3:0]     dec_tens, dec_units;
  logic [15:0]    dig_bcd;
  logic [3:0]     dig_blank;

  always_comb begin
    dec_val   = (bus.switchesH == MODE_FIRST) ? ffk : bus.K;
    dec_tens  = 4'((32'(dec_val) / 32'd10) % 32'd10);
    dec_units = 4'(32'(dec_val) % 32'd10);
    dig_bcd   = count;
    dig_blank = 4'b0000;
    case (bus.switchesH)
      MODE_COUNT: begin
`ifdef LEAD_ZERO_BLANK_EN
        dig_blank[3] = (count[15:12] == 4'd0);
        dig_blank[2] = dig_blank[3] && (count[11:8] == 4'd0);
        dig_blank[1] = dig_blank[2] && (count[7:4] == 4'd0);
`endif
      end
      MODE_FIRST: begin
        dig_bcd   = {8'h00, dec_tens, dec_units};
        dig_blank = ffv ? 4'b1100 : 4'b1111;
      end
      MODE_LIVE: begin
        dig_bcd   = {8'h00, dec_tens, dec_units};
        dig_blank = 4'b1100;
      end
      default: dig_blank = 4'b1111;
    endcase
  end

  logic [3:0][6:0] seg_comb;
  logic [3:0][6:0] disp_q;

  for (genvar g = 0; g < 4; g++) begin : g_digit
    bcd_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg (
      .bcd   (dig_bcd[g*4 +: 4]),
      .blank (dig_blank[g]),
      .seg   (seg_comb[g])
    );
  end

  always_ff @(posedge sys_clock or negedge sys_reset) begin
    if (!sys_reset) begin
      disp_q <= {SEG_RST_UPPER, SEG_RST_UPPER, SEG_RST_UPPER, SEG_ZERO_OUT};
    end else begin
      disp_q <= seg_comb;
    end
  end

  assign bus.dispUnidade = disp_q[0];
  assign bus.dispDezena  = disp_q[1];
  assign bus.dispCentena = disp_q[2];
  assign bus.dispMilhar  = disp_q[3];

endmodule

// File: tb/tb_error_count_display.sv
// Directed plus randomized bench for error_count_display against an integer-level reference model.
module tb_error_count_display;

  localparam int K_W = 6;
  localparam logic [6:0] BLK = 7'h7F;
  localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam int POW10 [4] = '{1, 10, 100, 1000};
`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [6:0] UPPER_ZERO = 7'h7F;
`else
  localparam logic [6:0] UPPER_ZERO = 7'h40;
`endif

  logic sys_clock = 1'b0;
  logic sys_reset = 1'b0;

  error_count_display_if #(.K_W(K_W)) bus ();

  error_count_display #(.K_W(K_W), .SEG_ACTIVE_LOW(1'b1)) dut (
    .sys_clock (sys_clock),
    .sys_reset (sys_reset),
    .bus       (bus)
  );

  always #5 sys_clock = ~sys_clock;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model: plain decimal count, 0=run 1=frozen 2=saturated.
  int         m_count, m_state, m_ffk;
  bit         m_ffv, m_sat, m_eprev, m_cprev;
  logic [6:0] m_disp [4];

  function automatic void set_disp(input int cnt, input int mode, input bit ffv,
                                   input int ffk, input int k);
    for (int i = 0; i < 4; i++) m_disp[i] = BLK;
    if (mode == 0) begin
      for (int i = 0; i < 4; i++) m_disp[i] = SEG_TAB[(cnt / POW10[i]) % 10];
`ifdef LEAD_ZERO_BLANK_EN
      for (int i = 1; i < 4; i++) if (cnt < POW10[i]) m_disp[i] = BLK;
`endif
    end else if (mode == 1 && ffv) begin
      m_disp[0] = SEG_TAB[ffk % 10];
      m_disp[1] = SEG_TAB[(ffk / 10) % 10];
    end else if (mode == 2) begin
      m_disp[0] = SEG_TAB[k % 10];
      m_disp[1] = SEG_TAB[(k / 10) % 10];
    end
  endfunction

  function automatic void model_reset();
    m_count = 0; m_state = 0; m_ffk = 0;
    m_ffv = 0; m_sat = 0; m_eprev = 0; m_cprev = 0;
    set_disp(0, 0, 1'b0, 0, 0);
  endfunction

  function automatic void model_edge();
    bit pulse, rise;
    set_disp(m_count, int'(bus.switchesH), m_ffv, m_ffk, int'(bus.K));
    pulse = bus.error_flag && !m_eprev;
    rise  = bus.continua && !m_cprev;
    if (bus.count_clear) begin
      m_count = 0; m_ffv = 0; m_ffk = 0; m_sat = 0; m_state = 0;
    end else if (m_state == 0) begin
      if (bus.stop) m_state = 1;
      else if (pulse) begin
        if (m_count == 0) begin
          m_ffk = int'(bus.K);
          m_ffv = 1;
        end
        m_count++;
        if (m_count == 9999) begin
          m_state = 2;
          m_sat   = 1;
        end
      end
    end else if (m_state == 1) begin
      if (rise && !bus.stop) m_state = 0;
    end
    m_eprev = bus.error_flag;
    m_cprev = bus.continua;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("dispUnidade", 32'(bus.dispUnidade), 32'(m_disp[0]));
    check("dispDezena", 32'(bus.dispDezena), 32'(m_disp[1]));
    check("dispCentena", 32'(bus.dispCentena), 32'(m_disp[2]));
    check("dispMilhar", 32'(bus.dispMilhar), 32'(m_disp[3]));
    check("first_fail_k", 32'(bus.first_fail_k), 32'(m_ffk));
    check("first_fail_valid", 32'(bus.first_fail_valid), 32'(m_ffv));
    check("err_saturated", 32'(bus.err_saturated), 32'(m_sat));
  endtask

  task automatic step(input bit chk);
    model_edge();
    @(posedge sys_clock);
    #1;
    if (chk) check_all();
  endtask

  task automatic pulse(input bit chk);
    bus.error_flag = 1'b1;
    step(chk);
    bus.error_flag = 1'b0;
    step(chk);
  endtask

  task automatic clear_count();
    bus.count_clear = 1'b1;
    step(1'b1);
    bus.count_clear = 1'b0;
    step(1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.error_flag  = 1'b0;
    bus.K           = '0;
    bus.stop        = 1'b0;
    bus.continua    = 1'b0;
    bus.count_clear = 1'b0;
    bus.switchesH   = 3'd0;
    model_reset();
    repeat (2) @(posedge sys_clock);
    #1;
    check_all();
    check("reset_units", 32'(bus.dispUnidade), 32'(7'h40));
    check("reset_milhar", 32'(bus.dispMilhar), 32'(UPPER_ZERO));
    #2 sys_reset = 1'b1;
    step(1'b1);

    // Three separate pulses in count mode.
    for (int i = 0; i < 3; i++) begin
      bus.K = K_W'($urandom);
      pulse(1'b1);
    end
    step(1'b1);
    check("three_units", 32'(bus.dispUnidade), 32'(7'h30));
    check("three_dezena", 32'(bus.dispDezena), 32'(UPPER_ZERO));

    // Held-high error_flag counts once.
    clear_count();
    bus.error_flag = 1'b1;
    repeat (20) step(1'b1);
    bus.error_flag = 1'b0;
    step(1'b1);
    step(1'b1);
    check("held_units", 32'(bus.dispUnidade), 32'(7'h79));

    // First-fail latch and mode 1 readout.
    clear_count();
    bus.K = 6'd37;
    pulse(1'b1);
    bus.K = 6'd5;
    pulse(1'b1);
    check("ffk_37", 32'(bus.first_fail_k), 32'd37);
    check("ffv_set", 32'(bus.first_fail_valid), 32'd1);
    bus.switchesH = 3'd1;
    step(1'b1);
    check("mode1_dezena", 32'(bus.dispDezena), 32'(7'h30));
    check("mode1_units", 32'(bus.dispUnidade), 32'(7'h78));
    check("mode1_milhar", 32'(bus.dispMilhar), 32'(BLK));
    bus.switchesH = 3'd2;
    step(1'b1);
    step(1'b1);

    // Freeze/resume: same-cycle pulse and frozen pulses are dropped.
    bus.switchesH = 3'd0;
    clear_count();
    bus.stop       = 1'b1;
    bus.error_flag = 1'b1;
    step(1'b1);
    bus.error_flag = 1'b0;
    step(1'b1);
    repeat (5) pulse(1'b1);
    bus.continua = 1'b1;
    step(1'b1);
    bus.continua = 1'b0;
    bus.stop     = 1'b0;
    step(1'b1);
    pulse(1'b1);
    step(1'b1);
    check("frozen_still_zero", 32'(bus.dispUnidade), 32'(7'h40));
    bus.continua = 1'b1;
    step(1'b1);
    bus.continua = 1'b0;
    step(1'b1);
    pulse(1'b1);
    step(1'b1);
    check("resume_units", 32'(bus.dispUnidade), 32'(7'h79));

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bus.error_flag  = 1'($urandom_range(0, 1));
      bus.K           = K_W'($urandom);
      bus.stop        = ($urandom_range(0, 7) == 0);
      bus.continua    = 1'($urandom_range(0, 1));
      bus.count_clear = ($urandom_range(0, 39) == 0);
      bus.switchesH   = 3'($urandom_range(0, 7));
      step(1'b1);
    end
    bus.stop = 1'b0; bus.continua = 1'b0; bus.count_clear = 1'b0;
    bus.error_flag = 1'b0; bus.switchesH = 3'd0;
    step(1'b1);

    // Saturation at 9999.
    clear_count();
    for (int i = 0; i < 9998; i++) pulse(1'b0);
    step(1'b1);
    check("pre_sat_units", 32'(bus.dispUnidade), 32'(7'h00));
    check("pre_sat_milhar", 32'(bus.dispMilhar), 32'(7'h10));
    check("pre_sat_flag", 32'(bus.err_saturated), 32'd0);
    pulse(1'b1);
    pulse(1'b1);
    step(1'b1);
    check("sat_flag", 32'(bus.err_saturated), 32'd1);
    check("sat_units", 32'(bus.dispUnidade), 32'(7'h10));
    bus.stop = 1'b1;
    step(1'b1);
    bus.stop = 1'b0;
    bus.continua = 1'b1;
    pulse(1'b1);
    bus.continua = 1'b0;
    step(1'b1);
    check("sat_hold_units", 32'(bus.dispUnidade), 32'(7'h10));
    bus.error_flag  = 1'b1;
    bus.count_clear = 1'b1;
    step(1'b1);
    bus.count_clear = 1'b0;
    bus.error_flag  = 1'b0;
    step(1'b1);
    step(1'b1);
    check("clear_sat_flag", 32'(bus.err_saturated), 32'd0);
    check("clear_units", 32'(bus.dispUnidade), 32'(7'h40));
    pulse(1'b1);
    step(1'b1);
    check("run_after_clear", 32'(bus.dispUnidade), 32'(7'h79));

    // Asynchronous reset mid-count at 0123.
    clear_count();
    for (int i = 0; i < 123; i++) pulse(1'b0);
    step(1'b1);
    check("pre_rst_units", 32'(bus.dispUnidade), 32'(7'h30));
    #2 sys_reset = 1'b0;
    #1;
    model_reset();
    check_all();
    check("async_units", 32'(bus.dispUnidade), 32'(7'h40));
    bus.error_flag = 1'b1;
    @(posedge sys_clock);
    #1 bus.error_flag = 1'b0;
    @(posedge sys_clock);
    #3 sys_reset = 1'b1;
    step(1'b1);
    step(1'b1);
    check("rst_pulse_dropped", 32'(bus.dispUnidade), 32'(7'h40));
    pulse(1'b1);
    step(1'b1);
    check("post_rst_count", 32'(bus.dispUnidade), 32'(7'h79));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
